// File: rtl/deck_server.sv
// rtl/deck_server.sv - 52-card deck responder: LFSR Fisher-Yates shuffle, ready/valid card dealing.
module deck_server #(
  parameter logic [15:0] SEED           = 16'hACE1,
  parameter bit          AUTO_RESHUFFLE = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_request,
  input  logic       i_shuffle,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_cardValid,
  output logic [3:0] o_cardRank,
  output logic [1:0] o_cardSuit,
  output logic [5:0] o_cardsRemaining
);

  typedef enum logic [1:0] {FILL, SHUFFLE, READY, EMPTY} state_t;

  state_t      state, state_next;
  logic [5:0]  deck [0:51];
  logic [15:0] lfsr;
  logic [5:0]  idx;
  logic [1:0]  fill_suit;
  logic [3:0]  fill_rank;
  logic [5:0]  shuf_i;
  logic [5:0]  top;
  logic [5:0]  remaining;
  logic [5:0]  mask;
  logic [5:0]  j;
  logic        swap;
  logic        accept;
  logic        restart;

  // Smallest all-ones mask covering i keeps the candidate rejection rate below one half.
  always_comb begin
    mask = 6'd1;
    if (shuf_i[5])      mask = 6'd63;
    else if (shuf_i[4]) mask = 6'd31;
    else if (shuf_i[3]) mask = 6'd15;
    else if (shuf_i[2]) mask = 6'd7;
    else if (shuf_i[1]) mask = 6'd3;
  end

  assign j       = lfsr[5:0] & mask;
  assign swap    = (state == SHUFFLE) && (j <= shuf_i);
  assign accept  = (state == READY) && i_request && !i_shuffle;
  assign restart = ((state == READY) && i_shuffle) ||
                   ((state == EMPTY) && (AUTO_RESHUFFLE || i_shuffle));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= FILL;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    o_busy     = 1'b0;
    o_ready    = 1'b0;
    case (state)
      FILL: begin
        o_busy = 1'b1;
        if (idx == 6'd51) state_next = SHUFFLE;
      end
      SHUFFLE: begin
        o_busy = 1'b1;
        if (swap && shuf_i == 6'd1) state_next = READY;
      end
      READY: begin
        o_ready = 1'b1;
        if (i_shuffle) state_next = FILL;
        else if (accept && remaining == 6'd1) state_next = EMPTY;
      end
      EMPTY: begin
        if (restart) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      lfsr             <= SEED;
      idx              <= 6'd0;
      fill_suit        <= 2'd0;
      fill_rank        <= 4'd1;
      shuf_i           <= 6'd51;
      top              <= 6'd0;
      remaining        <= 6'd0;
      o_cardValid      <= 1'b0;
      o_cardRank       <= 4'd0;
      o_cardSuit       <= 2'd0;
      o_cardsRemaining <= 6'd0;
    end else begin
      lfsr        <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      o_cardValid <= accept;
      case (state)
        FILL: begin
          idx <= idx + 6'd1;
          if (fill_rank == 4'd13) begin
            fill_rank <= 4'd1;
            fill_suit <= fill_suit + 2'd1;
          end else begin
            fill_rank <= fill_rank + 4'd1;
          end
          if (idx == 6'd51) shuf_i <= 6'd51;
        end
        SHUFFLE: begin
          if (swap) begin
            shuf_i <= shuf_i - 6'd1;
            if (shuf_i == 6'd1) begin
              top              <= 6'd0;
              remaining        <= 6'd52;
              o_cardsRemaining <= 6'd52;
            end
          end
        end
        READY: begin
          if (accept) begin
            {o_cardSuit, o_cardRank} <= deck[top];
            top              <= top + 6'd1;
            remaining        <= remaining - 6'd1;
            o_cardsRemaining <= remaining - 6'd1;
          end
        end
        default: ;
      endcase
      // Any restart discards the undealt cards and re-primes the fill counters.
      if (restart) begin
        idx              <= 6'd0;
        fill_suit        <= 2'd0;
        fill_rank        <= 4'd1;
        top              <= 6'd0;
        remaining        <= 6'd0;
        o_cardsRemaining <= 6'd0;
      end
    end
  end

  // Deck storage carries no reset; FILL always rewrites every entry before use.
  always_ff @(posedge i_clk) begin
    if (state == FILL) begin
      deck[idx] <= {fill_suit, fill_rank};
    end else if (swap) begin
      deck[shuf_i] <= deck[j];
      deck[j]      <= deck[shuf_i];
    end
  end

endmodule

// File: tb/tb_deck_server.sv
// tb/tb_deck_server.sv - directed vector bench for deck_server with a shuffle reference model.
module tb_deck_server;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic request = 1'b0;
  logic shuffle = 1'b0;
  logic shuffle_m = 1'b0;

  logic       ready, busy, valid;
  logic [3:0] rank;
  logic [1:0] suit;
  logic [5:0] rem;
  logic       m_ready, m_busy, m_valid;
  logic [3:0] m_rank;
  logic [1:0] m_suit;
  logic [5:0] m_rem;
  logic       s_ready, s_busy, s_valid;
  logic [3:0] s_rank;
  logic [1:0] s_suit;
  logic [5:0] s_rem;

  deck_server #(.SEED(16'hACE1), .AUTO_RESHUFFLE(1'b1)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_request(request), .i_shuffle(shuffle),
    .o_ready(ready), .o_busy(busy), .o_cardValid(valid), .o_cardRank(rank),
    .o_cardSuit(suit), .o_cardsRemaining(rem));

  deck_server #(.SEED(16'hACE1), .AUTO_RESHUFFLE(1'b0)) dut_m (
    .i_clk(clk), .i_reset(rst_n), .i_request(request), .i_shuffle(shuffle_m),
    .o_ready(m_ready), .o_busy(m_busy), .o_cardValid(m_valid), .o_cardRank(m_rank),
    .o_cardSuit(m_suit), .o_cardsRemaining(m_rem));

  deck_server #(.SEED(16'h1234), .AUTO_RESHUFFLE(1'b1)) dut_s (
    .i_clk(clk), .i_reset(rst_n), .i_request(request), .i_shuffle(1'b0),
    .o_ready(s_ready), .o_busy(s_busy), .o_cardValid(s_valid), .o_cardRank(s_rank),
    .o_cardSuit(s_suit), .o_cardsRemaining(s_rem));

  typedef struct {
    bit req;
    bit sh;
    bit exp_valid;
    bit exp_ready;
    int exp_rem;
    int card;
  } vec_t;

  int tests = 0;
  int fails = 0;
  logic [5:0] m_deck [52];
  int m_len;
  logic [5:0] got [52];
  logic [5:0] run1 [52];
  logic [5:0] s_expect;
  logic [5:0] s_first;
  logic s_seen = 1'b0;
  logic m_watch = 1'b0;
  int m_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  task automatic build_model(input logic [15:0] seed);
    logic [15:0] l;
    logic [5:0] t;
    int i, j, mk;
    for (int k = 0; k < 52; k++) m_deck[k] = 6'((k / 13) * 16 + (k % 13) + 1);
    l = seed;
    for (int k = 0; k < 52; k++) l = lfsr_next(l);
    i = 51;
    m_len = 0;
    while (i >= 1 && m_len < 10000) begin
      mk = 1;
      while (mk < i) mk = mk * 2 + 1;
      j = int'(l[5:0]) & mk;
      if (j <= i) begin
        t = m_deck[i];
        m_deck[i] = m_deck[j];
        m_deck[j] = t;
        i--;
      end
      m_len++;
      l = lfsr_next(l);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " busy"}, int'(busy), 1);
    chk({tag, " ready"}, int'(ready), 0);
    chk({tag, " valid"}, int'(valid), 0);
    chk({tag, " rank"}, int'(rank), 0);
    chk({tag, " suit"}, int'(suit), 0);
    chk({tag, " remaining"}, int'(rem), 0);
  endtask

  task automatic wait_ready(input string tag, output int cyc);
    cyc = 0;
    while (!ready && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " reached ready"}, int'(ready), 1);
  endtask

  task automatic deal_check(input string tag, input int first, input int n);
    int bad = 0;
    request = 1'b1;
    for (int k = first; k < first + n; k++) begin
      @(posedge clk); #1;
      got[k] = {suit, rank};
      if (valid !== 1'b1 || {suit, rank} !== m_deck[k] || int'(rem) != 51 - k) bad++;
    end
    request = 1'b0;
    chk({tag, " cards vs model"}, bad, 0);
  endtask

  task automatic perm_check(input string tag);
    bit seen [64];
    int bad = 0;
    for (int k = 0; k < 64; k++) seen[k] = 1'b0;
    for (int k = 0; k < 52; k++) begin
      if (got[k][3:0] < 4'd1 || got[k][3:0] > 4'd13 || seen[got[k]]) bad++;
      seen[got[k]] = 1'b1;
    end
    chk({tag, " permutation"}, bad, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && s_valid && !s_seen) begin
      s_first = {s_suit, s_rank};
      s_seen  = 1'b1;
    end
    if (m_watch && m_valid) m_bad++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [6];
    int cyc, busy_bad, pulses, same;

    vecs[0] = '{0, 0, 0, 1, 52, -1};
    vecs[1] = '{1, 0, 1, 1, 51, 0};
    vecs[2] = '{1, 0, 1, 1, 50, 1};
    vecs[3] = '{0, 0, 0, 1, 50, 1};
    vecs[4] = '{1, 0, 1, 1, 49, 2};
    vecs[5] = '{0, 0, 0, 1, 49, 2};

    build_model(16'h1234);
    s_expect = m_deck[0];
    build_model(16'hACE1);

    #12;
    chk_reset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    cyc = 0; busy_bad = 0; pulses = 0;
    while (!ready && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (!ready && !busy) busy_bad++;
      if (valid) pulses++;
    end
    chk("busy length", cyc, 52 + m_len);
    chk("busy held", busy_bad, 0);
    chk("idle pulses", pulses, 0);
    chk("ready remaining", int'(rem), 52);
    chk("ready busy", int'(busy), 0);

    for (int n = 0; n < 6; n++) begin
      request = vecs[n].req;
      shuffle = vecs[n].sh;
      @(posedge clk); #1;
      chk($sformatf("vec%0d valid", n), int'(valid), int'(vecs[n].exp_valid));
      chk($sformatf("vec%0d ready", n), int'(ready), int'(vecs[n].exp_ready));
      chk($sformatf("vec%0d remaining", n), int'(rem), vecs[n].exp_rem);
      chk($sformatf("vec%0d card", n), int'({suit, rank}),
          (vecs[n].card < 0) ? 0 : int'(m_deck[vecs[n].card]));
    end
    request = 1'b0;
    got[0] = m_deck[0]; got[1] = m_deck[1]; got[2] = m_deck[2];

    deal_check("deal1", 3, 49);
    chk("last card ready", int'(ready), 0);
    chk("last card remaining", int'(rem), 0);
    perm_check("deal1");
    for (int k = 0; k < 52; k++) run1[k] = got[k];
    chk("manual empty ready", int'(m_ready), 0);

    @(posedge clk); #1;
    chk("auto refill busy", int'(busy), 1);
    chk("manual stays empty", int'(m_busy), 0);

    m_watch = 1'b1;
    request = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    request = 1'b0;
    wait_ready("auto reshuffle", cyc);
    chk("auto reshuffle remaining", int'(rem), 52);

    request = 1'b1;
    shuffle = 1'b1;
    @(posedge clk); #1;
    request = 1'b0;
    shuffle = 1'b0;
    chk("req+shuffle valid", int'(valid), 0);
    chk("req+shuffle busy", int'(busy), 1);
    chk("req+shuffle remaining", int'(rem), 0);
    wait_ready("req+shuffle", cyc);
    chk("req+shuffle refill", int'(rem), 52);

    m_watch = 1'b0;
    chk("manual empty pulses", m_bad, 0);
    chk("manual empty remaining", int'(m_rem), 0);
    shuffle_m = 1'b1;
    @(posedge clk); #1;
    shuffle_m = 1'b0;
    chk("manual shuffle busy", int'(m_busy), 1);
    cyc = 0;
    while (!m_ready && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("manual reached ready", int'(m_ready), 1);
    chk("manual remaining", int'(m_rem), 52);

    cyc = 0;
    request = 1'b1;
    while (!s_seen && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    request = 1'b0;
    chk("seed2 dealt", int'(s_seen), 1);
    chk("seed2 first card", int'(s_first), int'(s_expect));

    shuffle = 1'b1;
    @(posedge clk); #1;
    shuffle = 1'b0;
    repeat (60) @(posedge clk);
    #3;
    chk("mid shuffle busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_reset("reset in shuffle");
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready("after shuffle reset", cyc);
    chk("restart length", cyc, 52 + m_len);
    deal_check("deal10", 0, 10);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset("reset in deal");
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready("after deal reset", cyc);
    chk("redeal length", cyc, 52 + m_len);
    deal_check("redeal", 0, 52);
    perm_check("redeal");
    same = 0;
    for (int k = 0; k < 52; k++) if (got[k] === run1[k]) same++;
    chk("repeatable sequence", same, 52);
    chk("redeal ready", int'(ready), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/deck_server.md
# deck_server

Responder end of the card-request interface used by the game top level. It holds a 52-card deck in registers, builds and shuffles it with an LFSR-driven Fisher-Yates pass, and serves one card per accepted request through a ready/valid handshake. It reports how many cards remain and reshuffles when the deck runs out. The player and dealer hand controllers sit on the other side of this interface.

## Interface
- SEED, 16'hACE1: LFSR reset value; must be nonzero.
- AUTO_RESHUFFLE, 1: 1 = rebuild and reshuffle automatically when the deck is empty; 0 = wait for i_shuffle.
- Clocking: one clock; reset is asynchronous and active-low.
- i_clk  input  1  clock.
- i_reset  input  1  asynchronous, active-low reset.
- i_request  input  1  card request; sampled each rising edge.
- i_shuffle  input  1  force a full rebuild and reshuffle of all 52 cards.
- o_ready  output  1  a request will be accepted this cycle.
- o_busy  output  1  FILL or SHUFFLE in progress.
- o_cardValid  output  1  one-cycle pulse; o_cardRank/o_cardSuit valid.
- o_cardRank  output  4  1 = Ace … 13 = King.
- o_cardSuit  output  2  0..3.
- o_cardsRemaining  output  6  undealt cards, 0..52.

## Operation
- Storage: deck[0:51], 6-bit entries {suit[1:0], rank[3:0]}. Registers: top pointer (6 bits), remaining count (6 bits).
- LFSR: 16-bit Galois, taps 16'hB400. Advances every cycle in every state. Loads SEED on reset.
- FILL state
  - Counter idx 0..51 writes deck[idx] = {idx/13, idx%13+1}, one entry per cycle (a rank/suit counter pair is acceptable).
  - Enters SHUFFLE with i = 51.
- SHUFFLE state (one candidate per cycle)
  - j = lfsr[5:0] & mask(i), where mask(i) is the smallest 2^k−1 ≥ i.
  - If j ≤ i: swap deck[i] and deck[j] in the same cycle and decrement i. Otherwise retry next cycle.
  - After the i = 1 swap: top = 0, remaining = 52, go to READY.
- READY state
  - o_ready = 1.
  - Accept when i_request is high and i_shuffle is low: register deck[top] onto the card outputs, pulse o_cardValid, increment top, decrement remaining.
  - When remaining reaches 0, go to EMPTY.
- EMPTY state
  - o_ready = 0.
  - If AUTO_RESHUFFLE = 1, go to FILL on the next edge. Otherwise wait for i_shuffle, then go to FILL.
- i_shuffle
  - In READY or EMPTY: go to FILL, discarding the remaining cards.
  - In FILL or SHUFFLE: ignored.
- Simultaneous i_request and i_shuffle in READY: shuffle wins, no card is issued, o_cardValid stays 0.
- Requests while o_ready = 0 are ignored, not queued. The requester must hold or re-assert i_request.
- o_busy = (state == FILL or SHUFFLE). o_ready = (state == READY). Both are decoded from the state register.

## Timing
- Reset asserted: state = FILL, idx = 0, o_busy = 1, o_ready = 0, o_cardValid = 0, o_cardRank = 0, o_cardSuit = 0, o_cardsRemaining = 0, top = 0, LFSR = SEED.
- Reset deasserted mid-shuffle or mid-deal: restarts at FILL idx 0. Deck contents are not preserved.
- FILL takes exactly 52 cycles. SHUFFLE takes at least 51 cycles; the exact count depends on the LFSR.
- Deal latency: request sampled at edge k with o_ready = 1.
  - Card outputs, o_cardValid = 1 and the updated o_cardsRemaining appear after edge k.
  - o_cardValid returns to 0 after edge k+1 unless another request was accepted.
- Back-to-back requests are accepted every cycle.
- Last card: o_ready falls after the same edge that issues card 52.
- The card outputs hold their last value between pulses.
- o_cardsRemaining holds 0 through EMPTY, FILL and SHUFFLE, and becomes 52 on the edge entering READY.

## Test plan
- Reset then idle: o_busy = 1 for 52 + (SHUFFLE length) cycles, then o_ready = 1, o_cardsRemaining = 52, o_cardValid never pulsed.
- Deal 52 with i_request held high: 52 consecutive o_cardValid pulses; each {suit, rank} with rank 1..13 appears exactly once; o_cardsRemaining counts 51 down to 0; o_ready = 0 after the 52nd.
- AUTO_RESHUFFLE = 0: a request in EMPTY gives no pulse. i_shuffle leads to a FILL + SHUFFLE cycle, after which o_cardsRemaining = 52.
- i_request and i_shuffle high in the same READY cycle: no o_cardValid; o_busy = 1 next cycle; o_cardsRemaining later returns to 52.
- Reset pulse during SHUFFLE, then after 10 dealt cards: all outputs take their reset values immediately (asynchronously); full FILL restarts; the subsequent 52-card deal is a valid permutation.
- Same SEED, identical stimulus run twice: identical card sequence. A different SEED gives a different first card.
